// File: rtl/dma_utils_pkg.sv
// Shared types and constants for the DMA stream/burst engine.
package dma_utils_pkg;

  // Stream request as issued by dma_fsm; fields sized for the widest supported address.
  typedef struct packed {
    logic [63:0] addr;
    logic [63:0] num_bytes;
    logic        mode;
  } stream_req_t;

  typedef enum logic [1:0] {
    AXI_BURST_FIXED = 2'b00,
    AXI_BURST_INCR  = 2'b01
  } axi_burst_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_ADDR,
    ST_DONE
  } stream_state_e;

  localparam logic [11:0] AXI_4KB_BEATS_MASK = 12'hFFF;
  localparam int          AXI_4KB_BYTES      = 4096;
  localparam int          MAX_FIXED_LEN      = 16;

endpackage

// File: rtl/dma_streamer_if.sv
// Stream request and AXI AR/AW address channel bundle for dma_streamer.
interface dma_streamer_if #(
  parameter int ADDR_W = 32
);
  logic              dma_stream_valid_i;
  logic [ADDR_W-1:0] dma_stream_addr_i;
  logic [ADDR_W-1:0] dma_stream_num_bytes_i;
  logic              dma_stream_mode_i;
  logic              dma_stream_ready_o;
  logic              dma_stream_done_o;
  logic              abort_i;
  logic [ADDR_W-1:0] axi_addr_o;
  logic [7:0]        axi_len_o;
  logic [2:0]        axi_size_o;
  logic [1:0]        axi_burst_o;
  logic              axi_valid_o;
  logic              axi_ready_i;
  logic              pend_txn_o;

  modport slave (
    input  dma_stream_valid_i, dma_stream_addr_i, dma_stream_num_bytes_i,
           dma_stream_mode_i, abort_i, axi_ready_i,
    output dma_stream_ready_o, dma_stream_done_o, axi_addr_o, axi_len_o,
           axi_size_o, axi_burst_o, axi_valid_o, pend_txn_o
  );

  modport master (
    output dma_stream_valid_i, dma_stream_addr_i, dma_stream_num_bytes_i,
           dma_stream_mode_i, abort_i, axi_ready_i,
    input  dma_stream_ready_o, dma_stream_done_o, axi_addr_o, axi_len_o,
           axi_size_o, axi_burst_o, axi_valid_o, pend_txn_o
  );
endinterface

// File: rtl/dma_burst_calc.sv
// Combinational burst sizing: min of remaining beats, burst cap and (INCR only)
// beats left before the next 4 KB page boundary.
module dma_burst_calc
  import dma_utils_pkg::*;
#(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int MAX_BURST_LEN = 256
) (
  input  logic [11:0]       page_offset,
  input  logic [ADDR_W-1:0] remaining,
  input  logic              fixed_mode,
  output logic [8:0]        len_beats
);

  localparam int SIZE_LOG2 = $clog2(DATA_W / 8);

  logic [12:0]       page_beats;
  logic [12:0]       cap;
  logic [ADDR_W-1:0] cap_wide;

  // Page offset is beat aligned, so the shift is exact.
  always_comb begin
    page_beats = (13'(AXI_4KB_BYTES) - {1'b0, page_offset & AXI_4KB_BEATS_MASK}) >> SIZE_LOG2;
    if (fixed_mode) begin
      cap = 13'(MAX_FIXED_LEN);
    end else if (page_beats > 13'(MAX_BURST_LEN)) begin
      cap = 13'(MAX_BURST_LEN);
    end else begin
      cap = page_beats;
    end
    cap_wide = ADDR_W'(cap);
    if (remaining < cap_wide) begin
      len_beats = remaining[8:0];
    end else begin
      len_beats = cap[8:0];
    end
  end

endmodule

// File: rtl/dma_streamer.sv
// Splits a DMA stream request into AXI address-channel bursts (INCR or FIXED).
// Optional feature macro: DMA_STREAM_BURST_CNT_EN adds a saturating burst counter output.
module dma_streamer
  import dma_utils_pkg::*;
#(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int MAX_BURST_LEN = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  dma_streamer_if.slave        bus
`ifdef DMA_STREAM_BURST_CNT_EN
  ,
  output logic [15:0]          burst_cnt_o
`endif
);

  localparam int                BEAT_BYTES = DATA_W / 8;
  localparam int                SIZE_LOG2  = $clog2(BEAT_BYTES);
  localparam logic [ADDR_W-1:0] LSB_MASK   = ADDR_W'(BEAT_BYTES - 1);

  stream_state_e     state;
  stream_state_e     state_nxt;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] remaining;
  logic [ADDR_W-1:0] remaining_after;
  logic [ADDR_W-1:0] req_beats;
  logic              fixed_mode;
  logic [8:0]        len_q;
  logic [8:0]        calc_len;
  logic              abort_held;
  logic              abort_now;
  logic              accept;
  logic              handshake;

  assign req_beats       = bus.dma_stream_num_bytes_i >> SIZE_LOG2;
  assign remaining_after = remaining - ADDR_W'(len_q);
  assign abort_now       = bus.abort_i || abort_held;
  assign accept          = bus.dma_stream_valid_i && bus.dma_stream_ready_o;
  assign handshake       = (state == ST_ADDR) && bus.axi_ready_i;

  dma_burst_calc #(
    .ADDR_W        (ADDR_W),
    .DATA_W        (DATA_W),
    .MAX_BURST_LEN (MAX_BURST_LEN)
  ) u_burst_calc (
    .page_offset (cur_addr[11:0]),
    .remaining   (remaining),
    .fixed_mode  (fixed_mode),
    .len_beats   (calc_len)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt               = state;
    bus.dma_stream_ready_o  = 1'b0;
    bus.dma_stream_done_o   = 1'b0;
    bus.pend_txn_o          = (state != ST_IDLE);
    bus.axi_valid_o         = 1'b0;
    bus.axi_addr_o          = '0;
    bus.axi_len_o           = '0;
    bus.axi_size_o          = '0;
    bus.axi_burst_o         = '0;
    case (state)
      ST_IDLE: begin
        bus.dma_stream_ready_o = !bus.abort_i;
        if (bus.dma_stream_valid_i && !bus.abort_i) begin
          state_nxt = (req_beats == '0) ? ST_DONE : ST_CALC;
        end
      end
      ST_CALC: begin
        state_nxt = bus.abort_i ? ST_IDLE : ST_ADDR;
      end
      ST_ADDR: begin
        bus.axi_valid_o = 1'b1;
        bus.axi_addr_o  = cur_addr;
        bus.axi_len_o   = 8'(len_q - 9'd1);
        bus.axi_size_o  = 3'(SIZE_LOG2);
        bus.axi_burst_o = fixed_mode ? AXI_BURST_FIXED : AXI_BURST_INCR;
        // An abort only takes effect once the outstanding address is accepted.
        if (bus.axi_ready_i) begin
          if (abort_now) begin
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = (remaining_after == '0) ? ST_DONE : ST_CALC;
          end
        end
      end
      ST_DONE: begin
        bus.dma_stream_done_o = !bus.abort_i;
        state_nxt             = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_addr   <= '0;
      remaining  <= '0;
      fixed_mode <= 1'b0;
      len_q      <= '0;
      abort_held <= 1'b0;
    end else begin
      if (accept) begin
        cur_addr   <= bus.dma_stream_addr_i & ~LSB_MASK;
        remaining  <= req_beats;
        fixed_mode <= bus.dma_stream_mode_i;
      end
      if (state == ST_CALC) begin
        len_q <= calc_len;
      end
      if (handshake) begin
        remaining <= remaining_after;
        if (!fixed_mode) begin
          cur_addr <= cur_addr + (ADDR_W'(len_q) << SIZE_LOG2);
        end
      end
      abort_held <= (state == ST_ADDR) && !bus.axi_ready_i && abort_now;
    end
  end

`ifdef DMA_STREAM_BURST_CNT_EN
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      burst_cnt_o <= '0;
    end else if (handshake && (burst_cnt_o != 16'hFFFF)) begin
      burst_cnt_o <= burst_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dma_streamer.sv
// Self-checking bench for dma_streamer: burst-list model plus directed literal checks.
module tb_dma_streamer;
  import dma_utils_pkg::*;

  localparam int ADDR_W        = 32;
  localparam int DATA_W        = 32;
  localparam int MAX_BURST_LEN = 256;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [1:0]  burst;
  } burst_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dma_streamer_if #(.ADDR_W(ADDR_W)) bus ();

`ifdef DMA_STREAM_BURST_CNT_EN
  logic [15:0] burst_cnt;
`endif

  dma_streamer #(
    .ADDR_W        (ADDR_W),
    .DATA_W        (DATA_W),
    .MAX_BURST_LEN (MAX_BURST_LEN)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef DMA_STREAM_BURST_CNT_EN
    ,
    .burst_cnt_o (burst_cnt)
`endif
  );

  burst_t exp_q[$];
  burst_t obs_q[$];
  burst_t obs_tmp;
  int     checks = 0;
  int     errors = 0;
  int     done_cnt = 0;
  int     valid_wait = 0;
  int     ready_delay = 0;
  int     ready_wait = 0;
  bit     exp_done = 1'b0;
  bit     exp_done_next = 1'b0;
  bit     abort_seen = 1'b0;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  // Reference burst list straight from the address/size rules, 4-byte beats.
  function automatic void model_request(input logic [31:0] addr, input logic [31:0] nbytes, input bit fixed);
    logic [31:0] a;
    longint      beats, n, to4k;
    a     = addr & ~32'h3;
    beats = longint'(nbytes) / 4;
    while (beats > 0) begin
      if (fixed) begin
        n = (beats < 16) ? beats : 16;
      end else begin
        to4k = (4096 - longint'(a & 32'hFFF)) / 4;
        n    = beats;
        if (n > 256) n = 256;
        if (n > to4k) n = to4k;
      end
      exp_q.push_back('{a, 8'(n - 1), fixed ? 2'b00 : 2'b01});
      beats -= n;
      if (!fixed) a = a + 32'(n * 4);
    end
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      exp_done      = 1'b0;
      exp_done_next = 1'b0;
      valid_wait    = 0;
      abort_seen    = 1'b0;
    end else begin
      check_output("done_pulse", 64'(bus.dma_stream_done_o), 64'(exp_done));
      if (bus.dma_stream_done_o) done_cnt++;
      if (valid_wait > 0) begin
        valid_wait--;
        check_output("valid_timing", 64'(bus.axi_valid_o), 64'(valid_wait == 0));
      end
      if (bus.axi_valid_o) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_valid: got valid=1 addr=0x%0h required no burst", bus.axi_addr_o);
        end else begin
          check_output("axi_addr", 64'(bus.axi_addr_o), 64'(exp_q[0].addr));
          check_output("axi_len", 64'(bus.axi_len_o), 64'(exp_q[0].len));
          check_output("axi_burst", 64'(bus.axi_burst_o), 64'(exp_q[0].burst));
          check_output("axi_size", 64'(bus.axi_size_o), 64'd2);
          if (bus.axi_ready_i) begin
            obs_tmp = '{bus.axi_addr_o, bus.axi_len_o, bus.axi_burst_o};
            obs_q.push_back(obs_tmp);
            void'(exp_q.pop_front());
            if (abort_seen || bus.abort_i) begin
              exp_q.delete();
              abort_seen = 1'b0;
            end else if (exp_q.size() == 0) begin
              exp_done_next = 1'b1;
            end else begin
              valid_wait = 2;
            end
          end else if (bus.abort_i) begin
            abort_seen = 1'b1;
          end
        end
      end
      if (bus.dma_stream_valid_i && bus.dma_stream_ready_o) begin
        model_request(bus.dma_stream_addr_i, bus.dma_stream_num_bytes_i, bus.dma_stream_mode_i);
        if (exp_q.size() == 0) exp_done_next = 1'b1;
        else valid_wait = 2;
      end
      exp_done      = exp_done_next;
      exp_done_next = 1'b0;
    end
  end

  initial begin
    bus.axi_ready_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.axi_valid_o && ready_wait >= ready_delay) begin
        bus.axi_ready_i = 1'b1;
        ready_wait      = 0;
      end else if (bus.axi_valid_o) begin
        bus.axi_ready_i = 1'b0;
        ready_wait++;
      end else begin
        bus.axi_ready_i = 1'b0;
        ready_wait      = 0;
      end
    end
  end

  task automatic apply_stimulus(input stream_req_t req, input int delay);
    ready_delay = delay;
    obs_q.delete();
    done_cnt = 0;
    @(posedge clk);
    #1;
    bus.dma_stream_valid_i     = 1'b1;
    bus.dma_stream_addr_i      = req.addr[31:0];
    bus.dma_stream_num_bytes_i = req.num_bytes[31:0];
    bus.dma_stream_mode_i      = req.mode;
    @(negedge clk);
    #1;
    check_output("req_ready", 64'(bus.dma_stream_ready_o), 64'd1);
    @(posedge clk);
    #1;
    bus.dma_stream_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit finished = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      #1;
      if (!bus.pend_txn_o && exp_q.size() == 0 && !exp_done) begin
        finished = 1'b1;
        break;
      end
    end
    checks++;
    if (!finished) begin
      errors++;
      $display("[TB] FAIL %s_timeout: got still busy after 3000 cycles required idle", name);
    end
  endtask

  task automatic wait_valid(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #1;
      if (bus.axi_valid_o) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL %s_valid_timeout: got no axi_valid_o in 50 cycles required assertion", name);
    end
  endtask

  task automatic check_burst(input int idx, input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
    if (idx < obs_q.size()) begin
      check_output($sformatf("burst%0d_addr", idx), 64'(obs_q[idx].addr), 64'(addr));
      check_output($sformatf("burst%0d_len", idx), 64'(obs_q[idx].len), 64'(len));
      check_output($sformatf("burst%0d_type", idx), 64'(obs_q[idx].burst), 64'(burst));
    end else begin
      checks++;
      errors++;
      $display("[TB] FAIL burst%0d_missing: got %0d bursts required index %0d", idx, obs_q.size(), idx);
    end
  endtask

  task automatic check_reset_outputs();
    check_output("rst_axi_valid", 64'(bus.axi_valid_o), 64'd0);
    check_output("rst_done", 64'(bus.dma_stream_done_o), 64'd0);
    check_output("rst_pend", 64'(bus.pend_txn_o), 64'd0);
    check_output("rst_axi_addr", 64'(bus.axi_addr_o), 64'd0);
    check_output("rst_axi_len", 64'(bus.axi_len_o), 64'd0);
    check_output("rst_axi_size", 64'(bus.axi_size_o), 64'd0);
    check_output("rst_axi_burst", 64'(bus.axi_burst_o), 64'd0);
    check_output("rst_ready", 64'(bus.dma_stream_ready_o), 64'd1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got simulation still running required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.dma_stream_valid_i     = 1'b0;
    bus.dma_stream_addr_i      = '0;
    bus.dma_stream_num_bytes_i = '0;
    bus.dma_stream_mode_i      = 1'b0;
    bus.abort_i                = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    #1;
    check_reset_outputs();

    apply_stimulus('{addr: 64'h1000, num_bytes: 64'd64, mode: 1'b0}, 0);
    wait_idle("incr_single");
    check_output("incr_single_count", 64'(obs_q.size()), 64'd1);
    check_burst(0, 32'h1000, 8'd15, 2'b01);
    check_output("incr_single_done", 64'(done_cnt), 64'd1);

    apply_stimulus('{addr: 64'h0FF0, num_bytes: 64'd64, mode: 1'b0}, 1);
    wait_idle("incr_4k");
    check_output("incr_4k_count", 64'(obs_q.size()), 64'd2);
    check_burst(0, 32'h0FF0, 8'd3, 2'b01);
    check_burst(1, 32'h1000, 8'd11, 2'b01);
`ifdef DMA_STREAM_BURST_CNT_EN
    check_output("burst_cnt", 64'(burst_cnt), 64'd2);
`endif

    apply_stimulus('{addr: 64'h0, num_bytes: 64'd2048, mode: 1'b0}, 0);
    wait_idle("incr_max");
    check_output("incr_max_count", 64'(obs_q.size()), 64'd2);
    check_burst(0, 32'h0, 8'd255, 2'b01);
    check_burst(1, 32'h400, 8'd255, 2'b01);

    apply_stimulus('{addr: 64'h2000, num_bytes: 64'd80, mode: 1'b1}, 2);
    wait_idle("fixed");
    check_output("fixed_count", 64'(obs_q.size()), 64'd2);
    check_burst(0, 32'h2000, 8'd15, 2'b00);
    check_burst(1, 32'h2000, 8'd3, 2'b00);

    apply_stimulus('{addr: 64'h5000, num_bytes: 64'd0, mode: 1'b0}, 0);
    wait_idle("zero");
    check_output("zero_count", 64'(obs_q.size()), 64'd0);
    check_output("zero_done", 64'(done_cnt), 64'd1);

    apply_stimulus('{addr: 64'h1003, num_bytes: 64'd10, mode: 1'b0}, 0);
    wait_idle("unaligned");
    check_burst(0, 32'h1000, 8'd1, 2'b01);

    apply_stimulus('{addr: 64'hFFFF_FFF0, num_bytes: 64'd64, mode: 1'b0}, 0);
    wait_idle("wrap");
    check_burst(0, 32'hFFFF_FFF0, 8'd3, 2'b01);
    check_burst(1, 32'h0, 8'd11, 2'b01);

    apply_stimulus('{addr: 64'h3000, num_bytes: 64'd4096, mode: 1'b0}, 0);
    wait_idle("page");
    check_output("page_count", 64'(obs_q.size()), 64'd4);
    check_burst(3, 32'h3C00, 8'd255, 2'b01);

    apply_stimulus('{addr: 64'h0, num_bytes: 64'd2048, mode: 1'b0}, 5);
    wait_valid("abort");
    @(posedge clk);
    #1;
    bus.abort_i = 1'b1;
    @(posedge clk);
    #1;
    bus.abort_i = 1'b0;
    wait_idle("abort");
    check_output("abort_count", 64'(obs_q.size()), 64'd1);
    check_burst(0, 32'h0, 8'd255, 2'b01);
    check_output("abort_done", 64'(done_cnt), 64'd0);

    apply_stimulus('{addr: 64'h0, num_bytes: 64'd2048, mode: 1'b0}, 5);
    wait_valid("midrst");
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    #1;
    check_reset_outputs();
`ifdef DMA_STREAM_BURST_CNT_EN
    check_output("burst_cnt_rst", 64'(burst_cnt), 64'd0);
`endif

    apply_stimulus('{addr: 64'h1000, num_bytes: 64'd64, mode: 1'b0}, 0);
    wait_idle("recover");
    check_burst(0, 32'h1000, 8'd15, 2'b01);
    check_output("recover_done", 64'(done_cnt), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dma_streamer.md
DMA_STREAMER -- requirements
Module: dma_streamer

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address and byte-count width.
REQ-002 SHALL have parameter DATA_W, default 32, AXI data width in bits; legal values 32, 64, 128.
REQ-003 SHALL have parameter MAX_BURST_LEN, default 256, maximum beats per INCR burst; legal range 1..256.
REQ-004 SHALL have port clk  in  1  single clock.
REQ-005 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-006 SHALL have port dma_stream_valid_i  in  1  stream request from dma_fsm.
REQ-007 SHALL have port dma_stream_addr_i  in  ADDR_W  start byte address.
REQ-008 SHALL have port dma_stream_num_bytes_i  in  ADDR_W  transfer size in bytes.
REQ-009 SHALL have port dma_stream_mode_i  in  1  0=INCR, 1=FIXED.
REQ-010 SHALL have port dma_stream_ready_o  out  1  request accepted.
REQ-011 SHALL have port dma_stream_done_o  out  1  one-cycle pulse when all bursts are issued.
REQ-012 SHALL have port abort_i  in  1  abort request (clear_dma).
REQ-013 SHALL have ports axi_addr_o (ADDR_W), axi_len_o (8), axi_size_o (3), axi_burst_o (2) and axi_valid_o (1) out, and axi_ready_i (1) in, forming the AXI AR/AW address channel.
REQ-014 SHALL have port pend_txn_o  out  1  high whenever FSM is not IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, CALC, ADDR, DONE.
REQ-016 IDLE: dma_stream_ready_o=1; on valid&&ready SHALL latch addr, mode and beats = num_bytes >> log2(DATA_W/8); low address/size bits below the beat size are truncated.
REQ-017 IDLE: if latched beats==0, SHALL go to DONE; otherwise SHALL go to CALC.
REQ-018 CALC (INCR): len_beats SHALL be min(remaining, MAX_BURST_LEN, beats to next 4 KB boundary).
REQ-019 CALC (FIXED): len_beats SHALL be min(remaining, 16); no 4 KB check applies.
REQ-020 CALC SHALL register the result and go to ADDR; axi_valid_o therefore asserts 2 cycles after request acceptance.
REQ-021 ADDR: axi_valid_o=1; axi_addr_o=current address; axi_len_o=len_beats-1; axi_size_o=log2(DATA_W/8); axi_burst_o=01 for INCR, 00 for FIXED.
REQ-022 ADDR: all axi_*_o SHALL remain stable until axi_ready_i is sampled high.
REQ-023 On the ADDR handshake: remaining -= len_beats; for INCR, address += len_beats*(DATA_W/8); for FIXED, address is unchanged.
REQ-024 After the ADDR handshake, SHALL go to DONE if remaining==0, else to CALC.
REQ-025 DONE: dma_stream_done_o=1 for exactly one cycle, then SHALL go to IDLE.
REQ-026 abort_i in IDLE/CALC/DONE SHALL force IDLE next cycle with no done pulse.
REQ-027 abort_i in ADDR SHALL hold axi_valid_o until handshake, then go to IDLE without done; an abort is remembered if deasserted meanwhile.
REQ-028 Address arithmetic SHALL wrap modulo 2^ADDR_W.

Reset
REQ-029 On rst: FSM=IDLE; axi_valid_o, dma_stream_done_o, pend_txn_o=0; axi_addr_o, axi_len_o, axi_size_o, axi_burst_o=0; dma_stream_ready_o=1 from the first cycle after reset release.
REQ-030 Reset mid-burst SHALL discard all state, including an unacknowledged axi_valid_o.

Configuration
REQ-031 With DMA_STREAM_BURST_CNT_EN defined, SHALL add output burst_cnt_o (16 bits): counts completed address handshakes, saturates at 0xFFFF, clears on rst and on request acceptance.
REQ-032 Without DMA_STREAM_BURST_CNT_EN, the port and the counter SHALL be absent.

Structure
REQ-033 dma_utils_pkg SHALL hold the stream request struct, the AXI burst type enum (FIXED/INCR), and the constants AXI_4KB_BEATS_MASK and MAX_FIXED_LEN=16.
REQ-034 The burst-length min() logic SHALL be in combinational sub-module dma_burst_calc, instantiated once.

Verification (DATA_W=32, MAX_BURST_LEN=256)
REQ-035 addr 0x1000, 64 B, INCR -> one burst: addr 0x1000, len 15, size 2, burst 01; done pulse 1 cycle after handshake.
REQ-036 addr 0x0FF0, 64 B, INCR -> two bursts: 0x0FF0 len 3, then 0x1000 len 11.
REQ-037 addr 0x0, 2048 B, INCR -> two bursts: 0x0 len 255, then 0x400 len 255.
REQ-038 addr 0x2000, 80 B, FIXED -> two bursts: 0x2000 len 15 burst 00, then 0x2000 len 3.
REQ-039 num_bytes 0 -> axi_valid_o never asserts; done pulses the cycle after acceptance.
REQ-040 abort_i pulsed in ADDR with axi_ready_i low 5 cycles -> valid and address held stable; after handshake returns to IDLE, no done pulse; rst mid-burst -> all outputs at reset values next cycle.
